// File: rtl/noise_alpha_controller_if.sv
// Sample-stream / coefficient bundle between the audio front end and the
// noise-alpha controller. The producer drives samples and thresholds; the controller returns alpha.
interface noise_alpha_controller_if #(
  parameter int WIDTH = 16
);
  logic                    sample_valid;
  logic signed [WIDTH-1:0] x_in;
  logic [WIDTH-2:0]        open_thresh;
  logic [WIDTH-2:0]        close_thresh;
  logic signed [WIDTH-1:0] alpha;
  logic                    alpha_valid;
  logic                    gate_open;
  logic [WIDTH-2:0]        env_out;

  modport master (
    output sample_valid, x_in, open_thresh, close_thresh,
    input  alpha, alpha_valid, gate_open, env_out
  );

  modport slave (
    input  sample_valid, x_in, open_thresh, close_thresh,
    output alpha, alpha_valid, gate_open, env_out
  );
endinterface

// File: rtl/noise_alpha_controller.sv
// Peak-envelope follower plus hysteretic gate FSM that ramps the Q1.15 smoothing
// weight alpha between ALPHA_MIN (gate closed) and ALPHA_MAX (gate open).
module noise_alpha_controller #(
  parameter int WIDTH        = 16,
  parameter int ENV_SHIFT    = 6,
  parameter int ALPHA_MIN    = 1638,
  parameter int ALPHA_MAX    = 32767,
  parameter int ALPHA_STEP   = 2048,
  parameter int HOLD_SAMPLES = 4800
) (
  input logic                     clk,
  input logic                     reset,
  noise_alpha_controller_if.slave bus
);

  localparam int W1    = WIDTH + 1;
  localparam int CNT_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

  // A hold length of zero behaves like one: the counter loads 0 and releases next sample.
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_SAMPLES > 1) ? CNT_W'(HOLD_SAMPLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic signed [W1-1:0]    A_MIN_X  = W1'(ALPHA_MIN);
  localparam logic signed [W1-1:0]    A_MAX_X  = W1'(ALPHA_MAX);
  localparam logic signed [W1-1:0]    A_STEP_X = W1'(ALPHA_STEP);
  localparam logic signed [WIDTH-1:0] A_MIN    = WIDTH'(ALPHA_MIN);
  localparam logic signed [WIDTH-1:0] A_MAX    = WIDTH'(ALPHA_MAX);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_ATTACK  = 3'd1,
    S_OPEN    = 3'd2,
    S_HOLD    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  function automatic logic [WIDTH-2:0] f_abs_sat(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] mag;
    mag = x[WIDTH-1] ? -x : x;
    // Only -full-scale leaves the top bit set after negation.
    if (mag[WIDTH-1]) begin
      f_abs_sat = {(WIDTH-1){1'b1}};
    end else begin
      f_abs_sat = mag[WIDTH-2:0];
    end
  endfunction

  function automatic logic signed [WIDTH-1:0] f_ramp_up(input logic signed [WIDTH-1:0] a);
    logic signed [W1-1:0] sum;
    sum = $signed({a[WIDTH-1], a}) + A_STEP_X;
    if (sum > A_MAX_X) begin
      f_ramp_up = A_MAX;
    end else begin
      f_ramp_up = sum[WIDTH-1:0];
    end
  endfunction

  function automatic logic signed [WIDTH-1:0] f_ramp_dn(input logic signed [WIDTH-1:0] a);
    logic signed [W1-1:0] diff;
    diff = $signed({a[WIDTH-1], a}) - A_STEP_X;
    if (diff < A_MIN_X) begin
      f_ramp_dn = A_MIN;
    end else begin
      f_ramp_dn = diff[WIDTH-1:0];
    end
  endfunction

  state_t                  r_state;
  state_t                  w_state_n;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_n;
  logic [WIDTH-2:0]        r_env;
  logic [WIDTH-2:0]        w_env_n;
  logic [WIDTH-2:0]        w_abs;
  logic [WIDTH-2:0]        w_env_decay;
  logic signed [WIDTH-1:0] r_alpha;
  logic signed [WIDTH-1:0] w_alpha_n;
  logic signed [WIDTH-1:0] w_up;
  logic signed [WIDTH-1:0] w_dn;
  logic                    w_open_hit;
  logic                    w_below_close;
  logic                    w_gate_n;
  logic                    r_gate;
  logic                    r_alpha_valid;

  assign w_abs         = f_abs_sat(bus.x_in);
  assign w_env_decay   = r_env - (r_env >> ENV_SHIFT);
  assign w_env_n       = (w_abs > r_env) ? w_abs : w_env_decay;
  assign w_open_hit    = (w_env_n >= bus.open_thresh);
  assign w_below_close = (w_env_n < bus.close_thresh);
  assign w_up          = f_ramp_up(r_alpha);
  assign w_dn          = f_ramp_dn(r_alpha);

  // Gate next-state and next-alpha for the sample currently presented.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_alpha_n = r_alpha;
    case (r_state)
      S_CLOSED: begin
        if (w_open_hit) begin
          w_alpha_n = w_up;
          w_state_n = (w_up == A_MAX) ? S_OPEN : S_ATTACK;
        end else begin
          w_alpha_n = A_MIN;
          w_state_n = S_CLOSED;
        end
      end
      S_ATTACK: begin
        w_alpha_n = w_up;
        w_state_n = (w_up == A_MAX) ? S_OPEN : S_ATTACK;
      end
      S_OPEN: begin
        w_alpha_n = A_MAX;
        // Requiring both thresholds keeps a mis-ordered pair from bouncing the gate.
        if (w_below_close && !w_open_hit) begin
          w_state_n = S_HOLD;
          w_cnt_n   = HOLD_LOAD;
        end else begin
          w_state_n = S_OPEN;
        end
      end
      S_HOLD: begin
        w_alpha_n = A_MAX;
        if (w_open_hit) begin
          w_state_n = S_OPEN;
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_n = S_RELEASE;
        end else begin
          w_cnt_n   = r_cnt - CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (w_open_hit) begin
          w_alpha_n = w_up;
          w_state_n = (w_up == A_MAX) ? S_OPEN : S_ATTACK;
        end else begin
          w_alpha_n = w_dn;
          w_state_n = (w_dn == A_MIN) ? S_CLOSED : S_RELEASE;
        end
      end
      default: begin
        w_state_n = S_CLOSED;
        w_alpha_n = A_MIN;
        w_cnt_n   = {CNT_W{1'b0}};
      end
    endcase
    w_gate_n = (w_state_n == S_ATTACK) || (w_state_n == S_OPEN) || (w_state_n == S_HOLD);
  end

  // State and output registers advance only on valid samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_CLOSED;
      r_cnt         <= {CNT_W{1'b0}};
      r_env         <= {(WIDTH-1){1'b0}};
      r_alpha       <= A_MIN;
      r_gate        <= 1'b0;
      r_alpha_valid <= 1'b0;
    end else begin
      r_alpha_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        r_state <= w_state_n;
        r_cnt   <= w_cnt_n;
        r_env   <= w_env_n;
        r_alpha <= w_alpha_n;
        r_gate  <= w_gate_n;
      end else begin
        r_state <= r_state;
        r_cnt   <= r_cnt;
        r_env   <= r_env;
        r_alpha <= r_alpha;
        r_gate  <= r_gate;
      end
    end
  end

  assign bus.alpha       = r_alpha;
  assign bus.alpha_valid = r_alpha_valid;
  assign bus.gate_open   = r_gate;
  assign bus.env_out     = r_env;

endmodule

// File: tb/tb_noise_alpha_controller.sv
// Self-checking bench for noise_alpha_controller: vector table plus scoreboard queue,
// followed by hand-written gap and mid-hold reset sequences.
module tb_noise_alpha_controller;

  localparam int WIDTH = 16;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] alpha;
    logic               gate;
    logic [14:0]        env;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic valid_d;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t mon_e;
  vec_t last_v;
  int   checks = 0;
  int   errors = 0;
  int   m_env  = 0;

  always #5 clk = ~clk;

  noise_alpha_controller_if #(.WIDTH(WIDTH)) bus ();

  noise_alpha_controller #(
    .WIDTH(16), .ENV_SHIFT(6), .ALPHA_MIN(1638), .ALPHA_MAX(32767),
    .ALPHA_STEP(2048), .HOLD_SAMPLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Builds one expected record; the envelope follows the reference peak/decay rule.
  function automatic vec_t mk(input int x, input int a, input bit g);
    vec_t v;
    int   mag;
    mag = (x < 0) ? -x : x;
    if (mag > 32767) mag = 32767;
    if (mag > m_env) m_env = mag;
    else m_env = m_env - (m_env >> 6);
    v.x     = 16'(x);
    v.alpha = 16'(a);
    v.gate  = g;
    v.env   = 15'(m_env);
    return v;
  endfunction

  function automatic void add(input int x, input int a, input bit g);
    vecs.push_back(mk(x, a, g));
  endfunction

  function automatic int sat_up(input int a);
    return (a > 32767) ? 32767 : a;
  endfunction

  // Zeros while open until envelope falls below close threshold; last one enters HOLD.
  function automatic void to_hold();
    while ((m_env - (m_env >> 6)) >= 4096) add(0, 32767, 1'b1);
    add(0, 32767, 1'b1);
  endfunction

  function automatic void hold_release(input int n);
    int a;
    for (int h = 1; h <= 4; h++) add(0, 32767, (h < 4));
    for (int j = 1; j <= n; j++) begin
      a = 32767 - 2048 * j;
      if (a < 1638) a = 1638;
      add(0, a, 1'b0);
    end
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    bus.x_in         = v.x;
    bus.sample_valid = 1'b1;
    sb.push_back(v);
    last_v = v;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) valid_d <= 1'b0;
    else valid_d <= bus.sample_valid;
  end

  // Output monitor: alpha_valid must trail sample_valid by one cycle; pop and compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.alpha_valid !== valid_d || valid_d) chk("alpha_valid_timing", int'(bus.alpha_valid), int'(valid_d));
      if (bus.alpha_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_alpha_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("alpha", int'(bus.alpha), int'(mon_e.alpha));
          chk("gate_open", int'(bus.gate_open), int'(mon_e.gate));
          chk("env_out", int'(bus.env_out), int'(mon_e.env));
        end
      end
    end
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.x_in         = 16'sd0;
    bus.open_thresh  = 15'd8192;
    bus.close_thresh = 15'd4096;

    // Build the vector table
    for (int i = 0; i < 10; i++) add(0, 1638, 1'b0);
    for (int k = 1; k <= 16; k++) add(16384, sat_up(1638 + 2048 * k), 1'b1);
    add(16384, 32767, 1'b1);
    add(0, 32767, 1'b1);
    add(-32768, 32767, 1'b1);
    to_hold();
    hold_release(16);
    for (int k = 1; k <= 16; k++) add(16384, sat_up(1638 + 2048 * k), 1'b1);
    to_hold();
    hold_release(6);
    add(12000, 22527, 1'b1);
    for (int k = 1; k <= 5; k++) add(12000, sat_up(22527 + 2048 * k), 1'b1);
    to_hold();
    add(0, 32767, 1'b1);
    add(0, 32767, 1'b1);
    add(12000, 32767, 1'b1);
    to_hold();
    hold_release(3);

    repeat (3) @(negedge clk);
    chk("reset_alpha", int'(bus.alpha), 1638);
    chk("reset_gate", int'(bus.gate_open), 0);
    chk("reset_env", int'(bus.env_out), 0);
    chk("reset_valid", int'(bus.alpha_valid), 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();

    // Re-trigger from RELEASE (alpha 26623) then freeze mid-ATTACK
    drive(mk(16384, 28671, 1'b1));
    idle();
    bus.x_in = -16'sd32768;
    repeat (20) begin
      @(negedge clk);
      chk("gap_alpha", int'(bus.alpha), int'(last_v.alpha));
      chk("gap_gate", int'(bus.gate_open), int'(last_v.gate));
      chk("gap_env", int'(bus.env_out), int'(last_v.env));
    end
    drive(mk(16384, 30719, 1'b1));
    drive(mk(16384, 32767, 1'b1));
    while ((m_env - (m_env >> 6)) >= 4096) drive(mk(0, 32767, 1'b1));
    drive(mk(0, 32767, 1'b1));
    drive(mk(0, 32767, 1'b1));
    drive(mk(0, 32767, 1'b1));
    idle();
    drain();

    // Asynchronous reset while in HOLD
    chk("pre_reset_gate", int'(bus.gate_open), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_alpha", int'(bus.alpha), 1638);
    chk("mid_reset_gate", int'(bus.gate_open), 0);
    chk("mid_reset_env", int'(bus.env_out), 0);
    m_env = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(mk(0, 1638, 1'b0));
    drive(mk(16384, 3686, 1'b1));
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
